uart_tx_serializer: RTL



---
 rtl/uart_tx_serializer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer
//  Description : UART transmit serializer. Pops one word from the TX FIFO
//                per handshake and shifts it out as start bit, LSB-first
//                data, optional parity bit and 1 or 2 stop bits. The line
//                idles high; bit timing comes from an internal divider.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int WORD_SIZE    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 gclk,
    input  logic                 rstn,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(WORD_SIZE + 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_PARITY = 3'd3;
    localparam logic [2:0] c_S_STOP   = 3'd4;

    localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  c_DATA_LAST = BIT_W'(WORD_SIZE - 1);
    // Stop bits are counted on the same bit counter as the data bits.
    localparam logic [BIT_W-1:0]  c_STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              c_PAR_EN    = (PARITY_EN != 0);
    localparam logic              c_PAR_ODD   = (PARITY_ODD != 0);

    logic [2:0]           r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bit;
    logic [WORD_SIZE-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_done;
    logic                 w_baud_term;

    assign w_baud_term  = (r_baud == c_BAUD_LAST);
    assign data_ready_o = (r_state == c_S_IDLE);
    assign busy_o       = (r_state != c_S_IDLE);
    assign tx_o         = r_tx;
    assign done_o       = r_done;

    // Frame sequencer: state, divider, bit counter, shift register and line.
    always_ff @(posedge gclk) begin
        if (!rstn) begin
            r_state <= c_S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (data_valid_i) begin
                        // Parity is fixed at accept time from the latched word.
                        r_shift <= data_i;
                        r_par   <= (^data_i) ^ c_PAR_ODD;
                        r_tx    <= 1'b0;
                        r_state <= c_S_START;
                    end
                end
                c_S_START: begin
                    if (w_baud_term) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= c_S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                c_S_DATA: begin
                    if (w_baud_term) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[WORD_SIZE-1:1]};
                        if (r_bit == c_DATA_LAST) begin
                            r_bit <= '0;
                            if (c_PAR_EN) begin
                                r_tx    <= r_par;
                                r_state <= c_S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= c_S_STOP;
                            end
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                c_S_PARITY: begin
                    if (w_baud_term) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= c_S_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                c_S_STOP: begin
                    if (w_baud_term) begin
                        r_baud <= '0;
                        if (r_bit == c_STOP_LAST) begin
                            r_bit   <= '0;
                            r_tx    <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= c_S_IDLE;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
